// File: rtl/branch_target_buffer_pkg.sv
// Shared constants for the branch target buffer: branch type codes and
// 2-bit saturating counter states.
package branch_target_buffer_pkg;

    typedef enum logic [2:0] {
        NOBRANCH = 3'd0,
        BEQ      = 3'd1,
        BNE      = 3'd2,
        BLT      = 3'd3,
        BLTU     = 3'd4,
        BGE      = 3'd5,
        BGEU     = 3'd6
    } branch_type_e;

    localparam logic [1:0] CTR_SNT   = 2'b00;
    localparam logic [1:0] CTR_WNT   = 2'b01;
    localparam logic [1:0] CTR_WT    = 2'b10;
    localparam logic [1:0] CTR_ST    = 2'b11;
    localparam logic [1:0] CTR_RESET = CTR_WNT;

endpackage

// File: rtl/branch_target_buffer_sat_counter2.sv
// Next-state function of a 2-bit saturating taken/not-taken counter.
module sat_counter2
    import branch_target_buffer_pkg::*;
(
    input  logic [1:0] ctr_i,
    input  logic       taken_i,
    output logic [1:0] ctr_o
);

    always_comb begin
        ctr_o = ctr_i;
        if (taken_i) begin
            if (ctr_i != CTR_ST) ctr_o = ctr_i + 2'd1;
        end else begin
            if (ctr_i != CTR_SNT) ctr_o = ctr_i - 2'd1;
        end
    end

endmodule

// File: rtl/branch_target_buffer.sv
// Direct-mapped tagged BTB with 2-bit counters, F->D->E prediction pipeline and
// EX-stage mispredict detection/training. Optional BTB_STATS_EN adds counters.
module branch_target_buffer
    import branch_target_buffer_pkg::*;
#(
    parameter int ENTRIES = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] PCF,
    output logic        PredTakenF,
    output logic [31:0] PredTargetF,
    input  logic        StallD,
    input  logic        FlushD,
    input  logic        StallE,
    input  logic        FlushE,
    input  logic [2:0]  BranchTypeE,
    input  logic [31:0] PCE,
    input  logic        BranchE,
    input  logic [31:0] BranchTargetE,
    output logic        MispredictE,
    output logic [31:0] RecoverPCE
`ifdef BTB_STATS_EN
    ,
    output logic [31:0] StatBranches,
    output logic [31:0] StatMispredicts
`endif
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = 30 - IDX_W;

    logic [ENTRIES-1:0] valid_q;
    logic [TAG_W-1:0]   tag_q    [ENTRIES];
    logic [31:0]        target_q [ENTRIES];
    logic [1:0]         ctr_q    [ENTRIES];

    logic              predTakenD_q, predTakenD_d, predTakenE_q, predTakenE_d;
    logic [31:0]       predTargetD_q, predTargetD_d, predTargetE_q, predTargetE_d;

    logic [IDX_W-1:0]  idxF, idxE;
    logic [TAG_W-1:0]  tagF, tagE;
    logic              hitF, hitE, isBranchE, updateE;
    logic [1:0]        ctrNextE;
    logic              unused_pc_bits;

    assign unused_pc_bits = ^PCF[1:0];

    assign idxF = PCF[IDX_W+1:2];
    assign tagF = PCF[31:IDX_W+2];
    assign idxE = PCE[IDX_W+1:2];
    assign tagE = PCE[31:IDX_W+2];

    // Lookup reads the stored entry directly; a same-cycle update is not bypassed.
    assign hitF        = valid_q[idxF] && (tag_q[idxF] == tagF);
    assign PredTakenF  = hitF && ctr_q[idxF][1];
    assign PredTargetF = PredTakenF ? target_q[idxF] : 32'd0;

    always_comb begin
        predTakenD_d  = predTakenD_q;
        predTargetD_d = predTargetD_q;
        if (FlushD) begin
            predTakenD_d  = 1'b0;
            predTargetD_d = 32'd0;
        end else if (!StallD) begin
            predTakenD_d  = PredTakenF;
            predTargetD_d = PredTargetF;
        end
    end

    always_comb begin
        predTakenE_d  = predTakenE_q;
        predTargetE_d = predTargetE_q;
        if (FlushE) begin
            predTakenE_d  = 1'b0;
            predTargetE_d = 32'd0;
        end else if (!StallE) begin
            predTakenE_d  = predTakenD_q;
            predTargetE_d = predTargetD_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            predTakenD_q  <= 1'b0;
            predTargetD_q <= 32'd0;
            predTakenE_q  <= 1'b0;
            predTargetE_q <= 32'd0;
        end else begin
            predTakenD_q  <= predTakenD_d;
            predTargetD_q <= predTargetD_d;
            predTakenE_q  <= predTakenE_d;
            predTargetE_q <= predTargetE_d;
        end
    end

    // Gating with rst_n keeps the resolve outputs quiet while reset is held.
    assign isBranchE = rst_n && (BranchTypeE != NOBRANCH);
    assign updateE   = isBranchE && !StallE;
    assign hitE      = valid_q[idxE] && (tag_q[idxE] == tagE);

    always_comb begin
        MispredictE = 1'b0;
        RecoverPCE  = 32'd0;
        if (isBranchE) begin
            MispredictE = (predTakenE_q != BranchE) ||
                          (predTakenE_q && BranchE && (predTargetE_q != BranchTargetE));
            RecoverPCE  = BranchE ? BranchTargetE : PCE + 32'd4;
        end
    end

    sat_counter2 u_sat_counter2 (
        .ctr_i   (ctr_q[idxE]),
        .taken_i (BranchE),
        .ctr_o   (ctrNextE)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                tag_q[i]    <= '0;
                target_q[i] <= 32'd0;
                ctr_q[i]    <= CTR_RESET;
            end
        end else if (updateE) begin
            if (hitE) begin
                ctr_q[idxE] <= ctrNextE;
                if (BranchE) target_q[idxE] <= BranchTargetE;
            end else if (BranchE) begin
                valid_q[idxE]  <= 1'b1;
                tag_q[idxE]    <= tagE;
                target_q[idxE] <= BranchTargetE;
                ctr_q[idxE]    <= CTR_WT;
            end
        end
    end

`ifdef BTB_STATS_EN
    logic [31:0] statBranches_q, statMispredicts_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            statBranches_q    <= 32'd0;
            statMispredicts_q <= 32'd0;
        end else if (updateE) begin
            statBranches_q <= statBranches_q + 32'd1;
            if (MispredictE) statMispredicts_q <= statMispredicts_q + 32'd1;
        end
    end

    assign StatBranches    = statBranches_q;
    assign StatMispredicts = statMispredicts_q;
`endif

endmodule
